// File: rtl/seg_tube_driver.sv
// -----------------------------------------------------------------------------
// seg_tube_driver
//   IO-side responder for the CPU's seven-segment tube chip select. It accepts
//   16-bit IO stores gated by tube_ctrl, holds an 8-digit hex display image and
//   a per-digit blank mask, and time-multiplexes the 8-digit common-anode tube.
//
// Parameters
//   SCAN_DIV   clk cycles each digit stays lit (>= 1)
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   tube_ctrl  in   1   chip select from MemOrIO
//   io_write   in   1   IO write strobe, one cycle per store
//   io_addr    in   2   00 low half, 01 high half, 10 blank mask, 11 unused
//   io_wdata   in   16  store data
//   seg_en     out  8   digit enables, active-low, bit i = digit i (0 rightmost)
//   seg_out    out  8   segments, active-low, {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg_tube_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tube_ctrl,
  input  logic        io_write,
  input  logic [1:0]  io_addr,
  input  logic [15:0] io_wdata,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);

  localparam int                CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    REG_LOW   = 2'b00,
    REG_HIGH  = 2'b01,
    REG_BLANK = 2'b10,
    REG_NONE  = 2'b11
  } reg_sel_e;

  logic [31:0]      disp;
  logic [7:0]       blank;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt;

  // Hex digit to active-low segment pattern; dp (bit 7) is always off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] d);
    logic [7:0] s;
    // NOTE: s gets a default before the case so no path leaves it unassigned,
    // which keeps the decode purely combinational with no latch.
    s = 8'hFF;
    case (d)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Register file: display image and blank mask. Reset wins over a store in
  // the same cycle; after reset every digit is dark until software unblanks.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      disp  <= '0;
      blank <= 8'hFF;
    end else if (tube_ctrl && io_write) begin
      case (io_addr)
        REG_LOW:   disp[15:0]  <= io_wdata;
        REG_HIGH:  disp[31:16] <= io_wdata;
        REG_BLANK: blank       <= io_wdata[7:0];
        REG_NONE:  ;
        default:   ;
      endcase
    end
  end

  // Scan timer: each digit is held for SCAN_DIV cycles, then idx moves on.
  // idx is 3 bits, so 7 wraps naturally to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Output stage: decoded from the current registered state, so a store or an
  // idx change shows on the pins one edge later and no input reaches a pin
  // combinationally.
  logic [3:0] cur_digit;
  logic       cur_blank;

  assign cur_digit = disp[{idx, 2'b00} +: 4];
  assign cur_blank = blank[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_en  <= 8'hFF;
      seg_out <= 8'hFF;
    end else begin
      seg_en  <= cur_blank ? 8'hFF : ~(8'b1 << idx);
      seg_out <= cur_blank ? 8'hFF : hex_to_seg(cur_digit);
    end
  end

endmodule

// File: tb/tb_seg_tube_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_tube_driver
//   Directed bench for seg_tube_driver. Two instances share one stimulus bus:
//   dut4 scans with SCAN_DIV=4, dut1 with SCAN_DIV=1 (digit changes each cycle).
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_seg_tube_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        tube_ctrl;
  logic        io_write;
  logic [1:0]  io_addr;
  logic [15:0] io_wdata;
  logic [7:0]  seg_en4, seg_out4;
  logic [7:0]  seg_en1, seg_out1;

  int n_checks = 0;
  int n_fail   = 0;

  // Segment patterns for hex digits 0..F.
  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  seg_tube_driver #(.SCAN_DIV(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .tube_ctrl (tube_ctrl),
    .io_write  (io_write),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .seg_en    (seg_en4),
    .seg_out   (seg_out4)
  );

  seg_tube_driver #(.SCAN_DIV(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .tube_ctrl (tube_ctrl),
    .io_write  (io_write),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .seg_en    (seg_en1),
    .seg_out   (seg_out1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    tube_ctrl = 1'b1;
    io_write  = 1'b1;
    io_addr   = a;
    io_wdata  = d;
    step();
    tube_ctrl = 1'b0;
    io_write  = 1'b0;
  endtask

  // Advance until the chosen instance shows seg_en == val, within budget cycles.
  task automatic wait_en(input bit slow, input logic [7:0] val, input int budget,
                         input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if ((slow ? seg_en4 : seg_en1) === val) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: seg_en never reached %h within %0d cycles (last %h)",
               name, val, budget, slow ? seg_en4 : seg_en1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tube_ctrl = 1'b0; io_write = 1'b0; io_addr = 2'b00; io_wdata = '0;
    repeat (2) step();
    n_checks++;
    if (seg_en4 !== 8'hFF || seg_out4 !== 8'hFF || seg_en1 !== 8'hFF || seg_out1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_pins: got %h/%h %h/%h, want FF/FF FF/FF", seg_en4, seg_out4, seg_en1, seg_out1);
    end
    rst = 1'b0;
    do_write(2'b10, 16'h0000);
    do_write(2'b00, 16'h3210);
    repeat (5) step();
    // Mid-scan reset, held for two cycles.
    rst = 1'b1;
    repeat (2) step();
    n_checks++;
    if (seg_en4 !== 8'hFF || seg_out4 !== 8'hFF || seg_en1 !== 8'hFF || seg_out1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL midscan_reset_pins: got %h/%h %h/%h, want FF/FF FF/FF", seg_en4, seg_out4, seg_en1, seg_out1);
    end
    n_checks++;
    if (dut4.idx !== 3'd0 || dut4.cnt !== 2'd0 || dut1.idx !== 3'd0) begin
      n_fail++;
      $display("FAIL midscan_reset_scan: got idx4=%0d cnt4=%0d idx1=%0d, want 0 0 0", dut4.idx, dut4.cnt, dut1.idx);
    end
    n_checks++;
    if (dut4.disp !== 32'h0 || dut4.blank !== 8'hFF) begin
      n_fail++;
      $display("FAIL midscan_reset_regs: got disp=%h blank=%h, want 00000000 FF", dut4.disp, dut4.blank);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (dut4.cnt !== 2'd1 || dut4.idx !== 3'd0 || dut1.idx !== 3'd1 || seg_en4 !== 8'hFF) begin
      n_fail++;
      $display("FAIL post_reset_scan: got cnt4=%0d idx4=%0d idx1=%0d en4=%h, want 1 0 1 FF",
               dut4.cnt, dut4.idx, dut1.idx, seg_en4);
    end
  endtask

  task automatic test_scan();
    int d;
    do_write(2'b10, 16'h0000);
    do_write(2'b00, 16'h3210);
    do_write(2'b01, 16'h7654);
    wait_en(1'b1, 8'h7F, 64, "scan_sync7");
    wait_en(1'b1, 8'hFE, 8,  "scan_sync0");
    // First FE cycle is the start of digit 0's dwell; 33 samples cover a wrap.
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) step();
      d = (k / 4) % 8;
      n_checks++;
      if (seg_en4 !== ~(8'b1 << d) || seg_out4 !== hex_tbl[d]) begin
        n_fail++;
        $display("FAIL scan_k%0d: got %h/%h, want %h/%h", k, seg_en4, seg_out4, ~(8'b1 << d), hex_tbl[d]);
      end
    end
  endtask

  task automatic test_hex_decode();
    logic [7:0] exp_out [8] = '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    do_write(2'b01, 16'hFEDC);
    do_write(2'b00, 16'hBA98);
    wait_en(1'b0, 8'hFE, 16, "hex_sync");
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      n_checks++;
      if (seg_en1 !== ~(8'b1 << k) || seg_out1 !== exp_out[k]) begin
        n_fail++;
        $display("FAIL hex_digit%0d: got %h/%h, want %h/%h", k, seg_en1, seg_out1, ~(8'b1 << k), exp_out[k]);
      end
    end
  endtask

  task automatic test_blank();
    // Digits 4..7 then 0..3 with blank=0F and disp=FEDCBA98.
    logic [7:0] exp_en  [8] = '{8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp_out [8] = '{8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_write(2'b10, 16'hFF0F);
    wait_en(1'b0, 8'hEF, 16, "blank_sync");
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      n_checks++;
      if (seg_en1 !== exp_en[k] || seg_out1 !== exp_out[k]) begin
        n_fail++;
        $display("FAIL blank_k%0d: got %h/%h, want %h/%h", k, seg_en1, seg_out1, exp_en[k], exp_out[k]);
      end
    end
  endtask

  task automatic test_gating();
    tube_ctrl = 1'b0; io_write = 1'b1; io_addr = 2'b00; io_wdata = 16'h1234;
    step();
    tube_ctrl = 1'b1; io_write = 1'b0; io_addr = 2'b01;
    step();
    tube_ctrl = 1'b1; io_write = 1'b1; io_addr = 2'b11;
    step();
    tube_ctrl = 1'b1; io_write = 1'b0; io_addr = 2'b10;
    step();
    tube_ctrl = 1'b0; io_write = 1'b0;
    n_checks++;
    if (dut1.disp !== 32'hFEDC_BA98 || dut4.disp !== 32'hFEDC_BA98) begin
      n_fail++;
      $display("FAIL gating_disp: got %h %h, want FEDCBA98", dut1.disp, dut4.disp);
    end
    n_checks++;
    if (dut1.blank !== 8'h0F || dut4.blank !== 8'h0F) begin
      n_fail++;
      $display("FAIL gating_blank: got %h %h, want 0F", dut1.blank, dut4.blank);
    end
    wait_en(1'b0, 8'hEF, 16, "gating_sync");
    n_checks++;
    if (seg_out1 !== 8'hC6) begin
      n_fail++;
      $display("FAIL gating_pins: got %h, want C6", seg_out1);
    end
  endtask

  task automatic test_edge();
    do_write(2'b10, 16'h0000);
    // seg_en=BF means idx has just moved 6->7; the next edge moves it 7->0.
    wait_en(1'b0, 8'hBF, 16, "edge_sync");
    do_write(2'b00, 16'h000A);
    n_checks++;
    if (seg_en1 !== 8'h7F || seg_out1 !== 8'h8E) begin
      n_fail++;
      $display("FAIL edge_digit7: got %h/%h, want 7F/8E", seg_en1, seg_out1);
    end
    step();
    n_checks++;
    if (seg_en1 !== 8'hFE || seg_out1 !== 8'h88) begin
      n_fail++;
      $display("FAIL edge_new_digit0: got %h/%h, want FE/88", seg_en1, seg_out1);
    end
    // Reset coincident with a store: reset must win.
    rst = 1'b1;
    tube_ctrl = 1'b1; io_write = 1'b1; io_addr = 2'b00; io_wdata = 16'hFFFF;
    step();
    tube_ctrl = 1'b0; io_write = 1'b0;
    n_checks++;
    if (dut1.disp !== 32'h0 || dut1.blank !== 8'hFF || seg_en1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL rst_vs_write: got disp=%h blank=%h en=%h, want 00000000 FF FF",
               dut1.disp, dut1.blank, seg_en1);
    end
    rst = 1'b0;
    do_write(2'b10, 16'h0000);
    wait_en(1'b0, 8'hFE, 16, "rst_write_sync");
    n_checks++;
    if (seg_out1 !== 8'hC0) begin
      n_fail++;
      $display("FAIL rst_write_pins: got %h, want C0", seg_out1);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex_decode();
    test_blank();
    test_gating();
    test_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
